// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - dispatch and result port bundle for the integer execute stage
interface alu_exec_if #(
  parameter int ROB_POS_W = 4
);
  logic                 alu_en;
  logic [6:0]           alu_opcode;
  logic [2:0]           alu_funct3;
  logic                 alu_funct7;
  logic [31:0]          alu_val1;
  logic [31:0]          alu_val2;
  logic [31:0]          alu_imm;
  logic [31:0]          alu_pc;
  logic [ROB_POS_W-1:0] alu_rob_pos;

  logic                 alu_result;
  logic [ROB_POS_W-1:0] alu_result_rob_pos;
  logic [31:0]          alu_result_val;
  logic                 alu_result_jump;
  logic [31:0]          alu_result_pc;

  // Reservation-station side: issues ops, listens to the broadcast
  modport master (
    output alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_pc, alu_rob_pos,
    input  alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump,
           alu_result_pc
  );

  // Execute-stage side
  modport slave (
    input  alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_pc, alu_rob_pos,
    output alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump,
           alu_result_pc
  );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I integer execute stage with one-cycle registered result broadcast
module alu_exec #(
  parameter int ROB_POS_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         rollback,
  alu_exec_if.slave    bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] alu_out;
  logic        br_cond;
  logic [31:0] val_n;
  logic        jump_n;
  logic [31:0] pc_n;

  logic                 result_q;
  logic [ROB_POS_W-1:0] rob_pos_q;
  logic [31:0]          val_q;
  logic                 jump_q;
  logic [31:0]          pc_q;

  // Integer ALU for OP / OP-IMM; operand B is rs2 only for register-register ops
  always_comb begin
    op_b    = (bus.alu_opcode == OPC_OP) ? bus.alu_val2 : bus.alu_imm;
    shamt   = op_b[4:0];
    alu_out = 32'd0;
    case (bus.alu_funct3)
      3'b000: alu_out = (bus.alu_opcode == OPC_OP && bus.alu_funct7)
                        ? bus.alu_val1 - op_b : bus.alu_val1 + op_b;
      3'b001: alu_out = bus.alu_val1 << shamt;
      3'b010: alu_out = {31'd0, $signed(bus.alu_val1) < $signed(op_b)};
      3'b011: alu_out = {31'd0, bus.alu_val1 < op_b};
      3'b100: alu_out = bus.alu_val1 ^ op_b;
      3'b101: alu_out = bus.alu_funct7 ? $unsigned($signed(bus.alu_val1) >>> shamt)
                                       : bus.alu_val1 >> shamt;
      3'b110: alu_out = bus.alu_val1 | op_b;
      default: alu_out = bus.alu_val1 & op_b;
    endcase
  end

  // Branch condition always compares rs1 against rs2
  always_comb begin
    br_cond = 1'b0;
    case (bus.alu_funct3)
      3'b000:  br_cond = (bus.alu_val1 == bus.alu_val2);
      3'b001:  br_cond = (bus.alu_val1 != bus.alu_val2);
      3'b100:  br_cond = ($signed(bus.alu_val1) < $signed(bus.alu_val2));
      3'b101:  br_cond = ($signed(bus.alu_val1) >= $signed(bus.alu_val2));
      3'b110:  br_cond = (bus.alu_val1 < bus.alu_val2);
      3'b111:  br_cond = (bus.alu_val1 >= bus.alu_val2);
      default: br_cond = 1'b0;
    endcase
  end

  // Select rd value, taken flag and next PC per opcode; unknown opcodes fall through as a no-op
  always_comb begin
    pc_plus4    = bus.alu_pc + 32'd4;
    pc_plus_imm = bus.alu_pc + bus.alu_imm;
    val_n       = 32'd0;
    jump_n      = 1'b0;
    pc_n        = pc_plus4;
    case (bus.alu_opcode)
      OPC_OP, OPC_OP_IMM: val_n = alu_out;
      OPC_LUI:            val_n = bus.alu_imm;
      OPC_AUIPC:          val_n = pc_plus_imm;
      OPC_JAL: begin
        val_n  = pc_plus4;
        jump_n = 1'b1;
        pc_n   = pc_plus_imm;
      end
      OPC_JALR: begin
        val_n  = pc_plus4;
        jump_n = 1'b1;
        pc_n   = (bus.alu_val1 + bus.alu_imm) & ~32'h1;
      end
      OPC_BRANCH: begin
        jump_n = br_cond;
        pc_n   = br_cond ? pc_plus_imm : pc_plus4;
      end
      default: ;
    endcase
  end

  // Result register: rollback kills the pulse, rdy low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= 1'b0;
      rob_pos_q <= '0;
      val_q     <= 32'd0;
      jump_q    <= 1'b0;
      pc_q      <= 32'd0;
    end else if (rollback) begin
      result_q <= 1'b0;
    end else if (rdy) begin
      result_q <= bus.alu_en;
      if (bus.alu_en) begin
        rob_pos_q <= bus.alu_rob_pos;
        val_q     <= val_n;
        jump_q    <= jump_n;
        pc_q      <= pc_n;
      end
    end
  end

  assign bus.alu_result         = result_q;
  assign bus.alu_result_rob_pos = rob_pos_q;
  assign bus.alu_result_val     = val_q;
  assign bus.alu_result_jump    = jump_q;
  assign bus.alu_result_pc      = pc_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec
module tb_alu_exec;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic rollback;

  always #5 clk = ~clk;

  alu_exec_if #(.ROB_POS_W(RW)) bus();

  alu_exec #(.ROB_POS_W(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic res, input logic [RW-1:0] rob,
                         input logic [31:0] val, input logic jump, input logic [31:0] pc);
    chk({tag, ".result"},  {31'd0, bus.alu_result},            {31'd0, res});
    chk({tag, ".rob_pos"}, {28'd0, bus.alu_result_rob_pos},    {28'd0, rob});
    chk({tag, ".val"},     bus.alu_result_val,                 val);
    chk({tag, ".jump"},    {31'd0, bus.alu_result_jump},       {31'd0, jump});
    chk({tag, ".pc"},      bus.alu_result_pc,                  pc);
  endtask

  task automatic drive_op(input logic en, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [RW-1:0] rob);
    bus.alu_en      = en;
    bus.alu_opcode  = opc;
    bus.alu_funct3  = f3;
    bus.alu_funct7  = f7;
    bus.alu_val1    = v1;
    bus.alu_val2    = v2;
    bus.alu_imm     = imm;
    bus.alu_pc      = pc;
    bus.alu_rob_pos = rob;
  endtask

  // Reference: architectural RV32I semantics with plain integer arithmetic
  function automatic void ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   output logic [31:0] val, output logic jump,
                                   output logic [31:0] npc);
    int          sa, sb;
    logic [31:0] b;
    int          sh;
    logic        c;
    val  = 32'd0;
    jump = 1'b0;
    npc  = pc + 32'd4;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      b  = (opc == 7'b0110011) ? rs2 : imm;
      sa = a;
      sb = b;
      sh = int'(b % 32);
      case (f3)
        3'd0: val = (opc == 7'b0110011 && f7) ? a - b : a + b;
        3'd1: val = a << sh;
        3'd2: val = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: val = (a < b) ? 32'd1 : 32'd0;
        3'd4: val = a ^ b;
        3'd5: val = f7 ? 32'(sa >>> sh) : a >> sh;
        3'd6: val = a | b;
        default: val = a & b;
      endcase
    end else if (opc == 7'b0110111) begin
      val = imm;
    end else if (opc == 7'b0010111) begin
      val = pc + imm;
    end else if (opc == 7'b1101111) begin
      val = pc + 32'd4; jump = 1'b1; npc = pc + imm;
    end else if (opc == 7'b1100111) begin
      val = pc + 32'd4; jump = 1'b1; npc = (a + imm) & 32'hFFFF_FFFE;
    end else if (opc == 7'b1100011) begin
      sa = a;
      sb = rs2;
      case (f3)
        3'd0: c = (a == rs2);
        3'd1: c = (a != rs2);
        3'd4: c = (sa < sb);
        3'd5: c = (sa >= sb);
        3'd6: c = (a < rs2);
        3'd7: c = (a >= rs2);
        default: c = 1'b0;
      endcase
      jump = c;
      npc  = c ? pc + imm : pc + 32'd4;
    end
  endfunction

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm, pc;
    logic [RW-1:0] rob;
    logic [31:0] e_val;
    logic        e_jump;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] opc_pool [8];

  logic          m_res;
  logic [RW-1:0] m_rob;
  logic [31:0]   m_val;
  logic          m_jump;
  logic [31:0]   m_pc;

  initial begin
    vecs.push_back('{"add",    7'b0110011, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 4'd3, 32'h0, 1'b0, 32'h14});
    vecs.push_back('{"sub",    7'b0110011, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 4'd4, 32'hFFFF_FFFE, 1'b0, 32'h14});
    vecs.push_back('{"srai",   7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h20, 4'd5, 32'hF800_0000, 1'b0, 32'h24});
    vecs.push_back('{"srli",   7'b0010011, 3'b101, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h20, 4'd6, 32'h0800_0000, 1'b0, 32'h24});
    vecs.push_back('{"slti",   7'b0010011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h30, 4'd7, 32'd1, 1'b0, 32'h34});
    vecs.push_back('{"sltiu",  7'b0010011, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h30, 4'd8, 32'd0, 1'b0, 32'h34});
    vecs.push_back('{"blt",    7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd9, 32'd0, 1'b1, 32'hF8});
    vecs.push_back('{"bltu",   7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd10, 32'd0, 1'b0, 32'h104});
    vecs.push_back('{"jalr",   7'b1100111, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd2, 32'h200, 4'd11, 32'h204, 1'b1, 32'h1004});
    vecs.push_back('{"lui",    7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h40, 4'd12, 32'h1234_5000, 1'b0, 32'h44});
    vecs.push_back('{"auipc",  7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_2000, 32'hFFFF_F000, 4'd13, 32'h0000_1000, 1'b0, 32'hFFFF_F004});
    vecs.push_back('{"jal",    7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 4'd14, 32'd0, 1'b1, 32'h4});
    vecs.push_back('{"badopc", 7'b0000011, 3'b000, 1'b0, 32'h55, 32'h66, 32'h77, 32'h50, 4'd15, 32'd0, 1'b0, 32'h54});
    vecs.push_back('{"br010",  7'b1100011, 3'b010, 1'b0, 32'd5, 32'd5, 32'h40, 32'h60, 4'd1, 32'd0, 1'b0, 32'h64});
    vecs.push_back('{"addi_f7",7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'd3, 32'h70, 4'd2, 32'd8, 1'b0, 32'h74});
    vecs.push_back('{"beq",    7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'h10, 32'h80, 4'd3, 32'd0, 1'b1, 32'h90});

    opc_pool = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000000};

    rst_n    = 1'b0;
    rdy      = 1'b1;
    rollback = 1'b0;
    drive_op(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, '0);
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, '0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b1;

    // Directed vector table, back-to-back ops
    foreach (vecs[i]) begin
      drive_op(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].v1, vecs[i].v2,
               vecs[i].imm, vecs[i].pc, vecs[i].rob);
      @(negedge clk);
      chk_all(vecs[i].name, 1'b1, vecs[i].rob, vecs[i].e_val, vecs[i].e_jump, vecs[i].e_pc);
    end
    bus.alu_en = 1'b0;

    // Asynchronous reset while a pulse is on the port
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, '0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three consecutive ops, rollback on the second edge, then a two-cycle freeze
    drive_op(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd1, 32'd0, 32'd1, 32'h100, 4'd1);
    @(posedge clk); #1;
    chk_all("pipe_op1", 1'b1, 4'd1, 32'd2, 1'b0, 32'h104);
    drive_op(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd7, 32'd0, 32'd7, 32'h104, 4'd2);
    rollback = 1'b1;
    @(posedge clk); #1;
    chk("pipe_op2_flushed", {31'd0, bus.alu_result}, 32'd0);
    rollback = 1'b0;
    drive_op(1'b1, 7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hABCD_E000, 32'h108, 4'd3);
    @(posedge clk); #1;
    chk_all("pipe_op3", 1'b1, 4'd3, 32'hABCD_E000, 1'b0, 32'h10C);
    rdy = 1'b0;
    drive_op(1'b1, 7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h40, 32'h200, 4'd7);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("freeze%0d", k), 1'b1, 4'd3, 32'hABCD_E000, 1'b0, 32'h10C);
    end
    rdy = 1'b1;
    bus.alu_en = 1'b0;
    @(posedge clk); #1;
    chk_all("idle_hold", 1'b0, 4'd3, 32'hABCD_E000, 1'b0, 32'h10C);

    // Randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_res  = 1'b0; m_rob = '0; m_val = 32'd0; m_jump = 1'b0; m_pc = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] v1, v2, imm, pc;
      logic [6:0]  opc;
      logic        en;
      chk_all($sformatf("rand%0d", n), m_res, m_rob, m_val, m_jump, m_pc);
      v1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      v2  = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      opc = opc_pool[$urandom_range(0, 7)];
      en  = ($urandom_range(0, 3) != 0);
      rdy      = ($urandom_range(0, 4) != 0);
      rollback = ($urandom_range(0, 9) == 0);
      drive_op(en, opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), v1, v2, imm, pc,
               RW'($urandom_range(0, 15)));
      if (rollback) begin
        m_res = 1'b0;
      end else if (rdy) begin
        m_res = en;
        if (en) begin
          m_rob = bus.alu_rob_pos;
          ref_exec(bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, v1, v2, imm, pc,
                   m_val, m_jump, m_pc);
        end
      end
      @(negedge clk);
    end
    chk_all("rand_end", m_res, m_rob, m_val, m_jump, m_pc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
